// File: rtl/msi_cpu_emitter_if.sv
// CPU request, snooping-bus and snoop-input signals of the MSI CPU-side emitter.
// The master modport is the controller's view; slave is the environment's view.
interface msi_cpu_emitter_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              cpu_valid;
   logic              cpu_write;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_ready;
   logic              cpu_done;
   logic              cpu_hit;
   logic              bus_req;
   logic              bus_gnt;
   logic              bus_valid;
   logic [1:0]        bus_op;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wb;
   logic [ADDR_W-1:0] bus_wb_addr;
   logic              snoop_valid;
   logic [1:0]        snoop_op;
   logic [ADDR_W-1:0] snoop_addr;
   logic              snoop_flush;

   modport master (
      input  cpu_valid, cpu_write, cpu_addr, bus_gnt, snoop_valid, snoop_op, snoop_addr,
      output cpu_ready, cpu_done, cpu_hit, bus_req, bus_valid, bus_op, bus_addr,
      output bus_wb, bus_wb_addr, snoop_flush
   );

   modport slave (
      output cpu_valid, cpu_write, cpu_addr, bus_gnt, snoop_valid, snoop_op, snoop_addr,
      input  cpu_ready, cpu_done, cpu_hit, bus_req, bus_valid, bus_op, bus_addr,
      input  bus_wb, bus_wb_addr, snoop_flush
   );
endinterface

// File: rtl/msi_cpu_emitter.sv
// CPU-side MSI controller: direct-mapped tag/state array, turns CPU requests into hits or
// snooping-bus transactions, and applies foreign snoops to its own lines every cycle.
module msi_cpu_emitter #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INDEX_W = 2
) (
   input logic                clock,
   input logic                reset,
   msi_cpu_emitter_if.master  ifc
);
   localparam int unsigned NUM_LINES = 2 ** INDEX_W;
   localparam int unsigned TAG_W     = ADDR_W - INDEX_W;

   localparam logic [1:0] OpRead   = 2'b00;
   localparam logic [1:0] OpWrite  = 2'b01;
   localparam logic [1:0] OpInv    = 2'b10;
   localparam logic [1:0] LnInv    = 2'b00;
   localparam logic [1:0] LnExcl   = 2'b01;
   localparam logic [1:0] LnShared = 2'b10;

   typedef enum logic [2:0] {StIdle, StCheck, StWb, StArb, StIssue, StUpdate} state_e;

   state_e             state_q, state_d;
   logic               write_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [1:0]         op_q, op_d;
   logic               flush_q, flush_d;
   logic [1:0]         line_q [NUM_LINES];
   logic [1:0]         line_d [NUM_LINES];
   logic [TAG_W-1:0]   tag_q  [NUM_LINES];
   logic [TAG_W-1:0]   tag_d  [NUM_LINES];

   logic [INDEX_W-1:0] idx, snp_idx;
   logic [TAG_W-1:0]   tag, snp_tag;
   logic               hit, victim_inv, install;

   assign idx     = addr_q[INDEX_W-1:0];
   assign tag     = addr_q[ADDR_W-1:INDEX_W];
   assign snp_idx = ifc.snoop_addr[INDEX_W-1:0];
   assign snp_tag = ifc.snoop_addr[ADDR_W-1:INDEX_W];
   assign hit     = (line_q[idx] != LnInv) && (tag_q[idx] == tag);

   assign ifc.snoop_flush = flush_q;

   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      victim_inv      = 1'b0;
      install         = 1'b0;
      ifc.cpu_ready   = 1'b0;
      ifc.cpu_done    = 1'b0;
      ifc.cpu_hit     = 1'b0;
      ifc.bus_req     = 1'b0;
      ifc.bus_valid   = 1'b0;
      ifc.bus_op      = OpRead;
      ifc.bus_addr    = '0;
      ifc.bus_wb      = 1'b0;
      ifc.bus_wb_addr = '0;
      unique case (state_q)
         StIdle: begin
            ifc.cpu_ready = 1'b1;
            if (ifc.cpu_valid) state_d = StCheck;
         end
         StCheck: begin
            if (hit && (!write_q || line_q[idx] == LnExcl)) begin
               ifc.cpu_done = 1'b1;
               ifc.cpu_hit  = 1'b1;
               state_d      = StIdle;
            end else if (hit) begin
               op_d    = OpInv;
               state_d = StArb;
            end else begin
               op_d    = write_q ? OpWrite : OpRead;
               state_d = (line_q[idx] == LnExcl) ? StWb : StArb;
            end
         end
         StWb: begin
            ifc.bus_wb      = 1'b1;
            ifc.bus_wb_addr = {tag_q[idx], idx};
            victim_inv      = 1'b1;
            state_d         = StArb;
         end
         StArb: begin
            ifc.bus_req = 1'b1;
            if (ifc.bus_gnt) state_d = StIssue;
         end
         StIssue: begin
            ifc.bus_valid = 1'b1;
            ifc.bus_addr  = addr_q;
            // An upgrade whose copy was snooped away must fetch the block again.
            ifc.bus_op    = (op_q == OpInv && line_q[idx] == LnInv) ? OpWrite : op_q;
            state_d       = StUpdate;
         end
         StUpdate: begin
            ifc.cpu_done = 1'b1;
            install      = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Own-transaction line updates first, then the snoop on top of the resulting state.
   always_comb begin
      flush_d = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         line_d[i] = line_q[i];
         tag_d[i]  = tag_q[i];
         if (victim_inv && idx == INDEX_W'(i)) line_d[i] = LnInv;
         if (install && idx == INDEX_W'(i)) begin
            line_d[i] = write_q ? LnExcl : LnShared;
            tag_d[i]  = tag;
         end
         if (ifc.snoop_valid && snp_idx == INDEX_W'(i) && line_d[i] != LnInv &&
             tag_d[i] == snp_tag) begin
            case (ifc.snoop_op)
               OpRead: begin
                  if (line_d[i] == LnExcl) begin
                     line_d[i] = LnShared;
                     flush_d   = 1'b1;
                  end
               end
               OpWrite, OpInv: begin
                  if (line_d[i] == LnExcl) flush_d = 1'b1;
                  line_d[i] = LnInv;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         write_q <= 1'b0;
         addr_q  <= '0;
         op_q    <= OpRead;
         flush_q <= 1'b0;
         for (int i = 0; i < NUM_LINES; i++) begin
            line_q[i] <= LnInv;
            tag_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         flush_q <= flush_d;
         if (state_q == StIdle && ifc.cpu_valid) begin
            write_q <= ifc.cpu_write;
            addr_q  <= ifc.cpu_addr;
         end
         for (int i = 0; i < NUM_LINES; i++) begin
            line_q[i] <= line_d[i];
            tag_q[i]  <= tag_d[i];
         end
      end
   end
endmodule

// File: tb/tb_msi_cpu_emitter.sv
// Self-checking bench: directed scenarios plus randomized requests and snoops against a
// transaction-level MSI model of the line array.
module tb_msi_cpu_emitter;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   msi_cpu_emitter_if #(.ADDR_W(8)) ifc ();

   msi_cpu_emitter #(.ADDR_W(8), .INDEX_W(2)) dut (
      .clock (clock),
      .reset (reset),
      .ifc   (ifc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: per-line MSI state (0 I, 1 E, 2 S) and tag.
   logic [1:0] m_st  [4];
   logic [5:0] m_tag [4];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_st[i]  = 2'd0;
         m_tag[i] = 6'd0;
      end
   endtask

   // Applies a foreign op to the model; returns whether an exclusive line was downgraded.
   function automatic bit model_snoop(input logic [1:0] op, input logic [7:0] a);
      int i = int'(a[1:0]);
      bit fl = 1'b0;
      if (m_st[i] != 2'd0 && m_tag[i] == a[7:2]) begin
         if (op == 2'd0) begin
            if (m_st[i] == 2'd1) begin
               m_st[i] = 2'd2;
               fl = 1'b1;
            end
         end else if (op == 2'd1 || op == 2'd2) begin
            fl = (m_st[i] == 2'd1);
            m_st[i] = 2'd0;
         end
      end
      return fl;
   endfunction

   task automatic snoop_drive(input bit v, input logic [1:0] op, input logic [7:0] a);
      ifc.snoop_valid = v;
      ifc.snoop_op    = op;
      ifc.snoop_addr  = a;
   endtask

   task automatic idle_snoop(input logic [1:0] op, input logic [7:0] a);
      bit ef;
      snoop_drive(1'b1, op, a);
      ef = model_snoop(op, a);
      tick();
      snoop_drive(1'b0, 2'd0, 8'd0);
      check_eq("idle_flush", ifc.snoop_flush, ef);
   endtask

   task automatic do_req(input bit wr, input logic [7:0] a, input int gdly, input bit arb_snp,
                         input logic [1:0] sop, input logic [7:0] sa, input bit upd_snp,
                         input logic [1:0] uop);
      int         i = int'(a[1:0]);
      bit         hit, wb, ef;
      logic [1:0] op;
      logic [7:0] vaddr;
      hit = (m_st[i] != 2'd0) && (m_tag[i] == a[7:2]);
      check_eq("ready", ifc.cpu_ready, 1);
      ifc.cpu_valid = 1'b1;
      ifc.cpu_write = wr;
      ifc.cpu_addr  = a;
      tick();
      ifc.cpu_valid = 1'b0;
      if (hit && (!wr || m_st[i] == 2'd1)) begin
         check_eq("hit_done", ifc.cpu_done, 1);
         check_eq("hit_flag", ifc.cpu_hit, 1);
         check_eq("hit_no_req", ifc.bus_req, 0);
         tick();
         return;
      end
      check_eq("miss_no_done", ifc.cpu_done, 0);
      op    = hit ? 2'd2 : (wr ? 2'd1 : 2'd0);
      wb    = !hit && m_st[i] == 2'd1;
      vaddr = {m_tag[i], a[1:0]};
      tick();
      if (wb) begin
         check_eq("bus_wb", ifc.bus_wb, 1);
         check_eq("bus_wb_addr", ifc.bus_wb_addr, vaddr);
         m_st[i] = 2'd0;
         tick();
      end
      check_eq("no_wb", ifc.bus_wb, 0);
      for (int c = 0; c <= gdly; c++) begin
         check_eq("bus_req", ifc.bus_req, 1);
         check_eq("arb_no_valid", ifc.bus_valid, 0);
         ifc.bus_gnt   = (c == gdly);
         ifc.cpu_valid = 1'($urandom);
         ifc.cpu_addr  = 8'($urandom);
         ef = 1'b0;
         if (c == 0 && arb_snp) begin
            snoop_drive(1'b1, sop, sa);
            ef = model_snoop(sop, sa);
         end
         tick();
         snoop_drive(1'b0, 2'd0, 8'd0);
         if (c == 0 && arb_snp) check_eq("arb_flush", ifc.snoop_flush, ef);
      end
      ifc.bus_gnt   = 1'b0;
      ifc.cpu_valid = 1'b0;
      if (op == 2'd2 && m_st[i] == 2'd0) op = 2'd1;
      check_eq("bus_valid", ifc.bus_valid, 1);
      check_eq("bus_op", ifc.bus_op, op);
      check_eq("bus_addr", ifc.bus_addr, a);
      check_eq("issue_no_req", ifc.bus_req, 0);
      tick();
      check_eq("upd_done", ifc.cpu_done, 1);
      check_eq("upd_hit", ifc.cpu_hit, 0);
      check_eq("upd_no_valid", ifc.bus_valid, 0);
      m_st[i]  = wr ? 2'd1 : 2'd2;
      m_tag[i] = a[7:2];
      ef = 1'b0;
      if (upd_snp) begin
         snoop_drive(1'b1, uop, a);
         ef = model_snoop(uop, a);
      end
      tick();
      snoop_drive(1'b0, 2'd0, 8'd0);
      if (upd_snp) check_eq("upd_flush", ifc.snoop_flush, ef);
      check_eq("ready_after", ifc.cpu_ready, 1);
   endtask

   function automatic logic [7:0] rand_addr();
      logic [7:0] a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a[7] = 1'b1;
      return a;
   endfunction

   initial begin
      reset         = 1'b1;
      ifc.cpu_valid = 1'b0;
      ifc.cpu_write = 1'b0;
      ifc.cpu_addr  = 8'd0;
      ifc.bus_gnt   = 1'b0;
      snoop_drive(1'b0, 2'd0, 8'd0);
      model_clear();
      tick();
      tick();
      check_eq("rst_ready", ifc.cpu_ready, 1);
      check_eq("rst_done", ifc.cpu_done, 0);
      check_eq("rst_req", ifc.bus_req, 0);
      check_eq("rst_valid", ifc.bus_valid, 0);
      check_eq("rst_wb", ifc.bus_wb, 0);
      check_eq("rst_flush", ifc.snoop_flush, 0);
      reset = 1'b0;
      tick();

      do_req(1'b0, 8'h12, 0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);  // read miss
      do_req(1'b0, 8'h12, 0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);  // read hit
      do_req(1'b1, 8'h12, 1, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);  // upgrade
      idle_snoop(2'd0, 8'h12);                                 // E -> S with flush
      do_req(1'b1, 8'h22, 0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);
      do_req(1'b0, 8'h32, 0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);  // E victim write-back
      do_req(1'b0, 8'h05, 0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);
      do_req(1'b1, 8'h05, 5, 1'b1, 2'd2, 8'h05, 1'b0, 2'd0);  // upgrade turns write_miss
      do_req(1'b1, 8'h09, 0, 1'b0, 2'd0, 8'd0, 1'b1, 2'd0);  // install + snoop read_miss
      do_req(1'b1, 8'h09, 0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);  // now shared -> invalidate

      // Reset in the middle of arbitration.
      ifc.cpu_valid = 1'b1;
      ifc.cpu_write = 1'b1;
      ifc.cpu_addr  = 8'h33;
      tick();
      ifc.cpu_valid = 1'b0;
      tick();
      check_eq("pre_rst_req", ifc.bus_req, 1);
      #2 reset = 1'b1;
      #1;
      check_eq("mid_rst_req", ifc.bus_req, 0);
      check_eq("mid_rst_ready", ifc.cpu_ready, 1);
      check_eq("mid_rst_valid", ifc.bus_valid, 0);
      tick();
      reset = 1'b0;
      model_clear();
      do_req(1'b0, 8'h12, 0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0);  // must miss again

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) < 3) begin
            idle_snoop(2'($urandom), rand_addr());
         end else begin
            do_req(1'($urandom), rand_addr(), int'($urandom_range(0, 3)), 1'($urandom),
                   2'($urandom), rand_addr(), 1'($urandom), 2'($urandom));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
